// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RISC-V pipeline: load-use, branch redirect,
// variable-latency fetch and data-memory waits. Macro HAZARD_WATCHDOG_EN adds the wait watchdog.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       imem_ready,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic [4:0] rdE,
  input  logic       mem_readE,
  input  logic       pc_srcE,
  input  logic       dmem_reqM,
  input  logic       dmem_ready,
  output logic       pc_write,
  output logic       fetch_ack,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_write,
  output logic       id_ex_flush,
  output logic       ex_mem_write,
  output logic       mem_wb_flush,
  output logic       mem_timeout
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    IKILL = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   freeze;
  logic   lu;

  assign freeze = dmem_reqM & ~dmem_ready;
  assign lu     = mem_readE & (rdE != 5'd0) & ((rdE == rs1D) | (rdE == rs2D));

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    pc_write     = imem_ready;
    fetch_ack    = imem_ready;
    if_id_write  = 1'b1;
    if_id_flush  = ~imem_ready;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_flush = 1'b0;
    if (rst) begin
      state_nxt    = RUN;
      pc_write     = 1'b0;
      fetch_ack    = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_write  = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (freeze) begin
      // Whole pipe holds; branch and load-use are re-evaluated once MEM releases.
      pc_write     = 1'b0;
      fetch_ack    = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (state == IKILL) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
      fetch_ack   = imem_ready;
      if (imem_ready) state_nxt = RUN;
    end else if (pc_srcE) begin
      pc_write    = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      fetch_ack   = imem_ready;
      // A fetch still in flight belongs to the wrong path and must be discarded on return.
      if (!imem_ready) state_nxt = IKILL;
    end else if (lu) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      fetch_ack   = 1'b0;
    end
  end

`ifdef HAZARD_WATCHDOG_EN
  localparam int             CW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] wait_cnt;
  logic          timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (freeze) begin
      if (wait_cnt != LIMIT) wait_cnt <= wait_cnt + 1'b1;
      // Set on the edge that closes the TIMEOUT_CYC-th consecutive wait cycle.
      if (wait_cnt == LIMIT - 1'b1) timeout_q <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign mem_timeout = timeout_q;
`else
  assign mem_timeout = 1'b0;
`endif

endmodule
